// File: rtl/mips_pkg.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : mips_pkg                                                     |
// | Shared ISA types, state encoding and helpers for the multi-cycle core |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
package mips_pkg;

  typedef enum logic [2:0] {
    OP_RTYPE = 3'd0,
    OP_ADDI  = 3'd1,
    OP_LW    = 3'd2,
    OP_SW    = 3'd3,
    OP_BEQ   = 3'd4,
    OP_BNE   = 3'd5,
    OP_J     = 3'd6,
    OP_HALT  = 3'd7
  } opcode_e;

  typedef enum logic [3:0] {
    F_ADD = 4'd0,
    F_SUB = 4'd1,
    F_AND = 4'd2,
    F_OR  = 4'd3,
    F_SLT = 4'd4,
    F_XOR = 4'd5,
    F_SLL = 4'd6,
    F_SRL = 4'd7,
    F_JR  = 4'd8
  } funct_e;

  // funct kept as raw bits so undefined codes can be carried and flagged
  typedef struct packed {
    opcode_e    op;
    logic [2:0] rs;
    logic [2:0] rt;
    logic [2:0] rd;
    logic [3:0] funct;
  } instr_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    MEM   = 2'd2,
    HALT  = 2'd3
  } state_e;

  localparam int c_SEXT_W = 64;

  function automatic logic [c_SEXT_W-1:0] sext7(input logic [6:0] imm);
    return {{(c_SEXT_W-7){imm[6]}}, imm};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mips_alu.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : mips_alu                                                     |
// | Combinational R-type ALU; flags funct codes outside the defined set   |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module mips_alu
  import mips_pkg::*;
#(
  parameter int WIDTH = 16
) (
  input  logic [3:0]       funct,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] result,
  output logic             illegal_funct
);

  localparam int c_SH_W = $clog2(WIDTH);

  logic [c_SH_W-1:0] w_shamt;
  assign w_shamt = b[c_SH_W-1:0];

  always_comb begin
    result        = '0;
    illegal_funct = 1'b0;
    case (funct)
      F_ADD:   result = a + b;
      F_SUB:   result = a - b;
      F_AND:   result = a & b;
      F_OR:    result = a | b;
      F_SLT:   result = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      F_XOR:   result = a ^ b;
      F_SLL:   result = a << w_shamt;
      F_SRL:   result = a >> w_shamt;
      F_JR:    result = '0;
      default: illegal_funct = 1'b1;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/mips_multicycle_core.sv
`default_nettype none
// +-----------------------------------------------------------------------+
// | Module : mips_multicycle_core                                         |
// | Multi-cycle 16-bit MIPS-style core: fetch/exec/mem FSM, 8-entry regs  |
// | Rev    : 1.0                                                          |
// +-----------------------------------------------------------------------+
module mips_multicycle_core
  import mips_pkg::*;
#(
  parameter int              WIDTH    = 16,
  parameter int              PC_W     = 13,
  parameter int              ADDR_W   = 16,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter bit              R0_ZERO  = 1'b1
) (
  input  logic              clk,
  input  logic              rstn,
  output logic [PC_W-1:0]   pc,
  input  logic [15:0]       instr,
  input  logic              instr_valid,
  output logic              instr_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [WIDTH-1:0]  mem_wdata,
  input  logic [WIDTH-1:0]  mem_rdata,
  input  logic              mem_ack,
  input  logic [2:0]        dbg_sel,
  output logic [WIDTH-1:0]  dbg_data,
  output logic              halted,
  output logic              illegal
);

  state_e              r_state, w_state_next;
  instr_t              r_cir;
  logic [WIDTH-1:0]    r_regs [8];
  logic [PC_W-1:0]     r_pc, w_pc_next, w_pc_inc, w_pc_br, w_pc_tgt;
  logic                r_illegal, w_set_illegal;
  logic                r_mem_req, r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [WIDTH-1:0]    r_mem_wdata;
  logic                w_cir_load, w_mem_start;
  logic                w_wr_en;
  logic [2:0]          w_wr_idx;
  logic [WIDTH-1:0]    w_wr_data;
  logic [WIDTH-1:0]    w_rs_val, w_rt_val, w_imm, w_ea, w_alu_res;
  logic                w_alu_illegal;

  assign w_rs_val = r_regs[r_cir.rs];
  assign w_rt_val = r_regs[r_cir.rt];
  assign w_imm    = WIDTH'(sext7(r_cir[6:0]));
  assign w_ea     = w_rs_val + w_imm;
  assign w_pc_inc = r_pc + PC_W'(1);
  assign w_pc_br  = w_pc_inc + PC_W'(sext7(r_cir[6:0]));
  assign w_pc_tgt = PC_W'(r_cir[12:0]);

  mips_alu #(.WIDTH(WIDTH)) u_alu (
    .funct        (r_cir.funct),
    .a            (w_rs_val),
    .b            (w_rt_val),
    .result       (w_alu_res),
    .illegal_funct(w_alu_illegal)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) r_state <= FETCH;
    else       r_state <= w_state_next;
  end

  always_comb begin
    w_state_next  = r_state;
    instr_ready   = 1'b0;
    w_pc_next     = r_pc;
    w_cir_load    = 1'b0;
    w_mem_start   = 1'b0;
    w_set_illegal = 1'b0;
    w_wr_en       = 1'b0;
    w_wr_idx      = 3'd0;
    w_wr_data     = '0;
    case (r_state)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          w_cir_load   = 1'b1;
          w_state_next = EXEC;
        end
      end
      EXEC: begin
        w_state_next = FETCH;
        case (r_cir.op)
          OP_RTYPE: begin
            w_pc_next = w_pc_inc;
            if (r_cir.funct == F_JR) begin
              w_pc_next = PC_W'(w_rs_val);
            end else if (w_alu_illegal) begin
              w_set_illegal = 1'b1;
            end else begin
              w_wr_en   = 1'b1;
              w_wr_idx  = r_cir.rd;
              w_wr_data = w_alu_res;
            end
          end
          OP_ADDI: begin
            w_pc_next = w_pc_inc;
            w_wr_en   = 1'b1;
            w_wr_idx  = r_cir.rt;
            w_wr_data = w_ea;
          end
          OP_LW, OP_SW: begin
            w_mem_start  = 1'b1;
            w_state_next = MEM;
          end
          OP_BEQ:  w_pc_next = (w_rs_val == w_rt_val) ? w_pc_br : w_pc_inc;
          OP_BNE:  w_pc_next = (w_rs_val != w_rt_val) ? w_pc_br : w_pc_inc;
          OP_J:    w_pc_next = w_pc_tgt;
          OP_HALT: w_state_next = HALT;
          default: w_state_next = FETCH;
        endcase
      end
      MEM: begin
        if (mem_ack) begin
          w_pc_next    = w_pc_inc;
          w_state_next = FETCH;
          w_wr_en      = !r_mem_we;
          w_wr_idx     = r_cir.rt;
          w_wr_data    = mem_rdata;
        end
      end
      HALT:    w_state_next = HALT;
      default: w_state_next = FETCH;
    endcase
  end

  // Register file, pc and memory port; r0 simply never gets written when hardwired
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_pc        <= RESET_PC;
      r_cir       <= '0;
      r_illegal   <= 1'b0;
      r_mem_req   <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_addr  <= '0;
      r_mem_wdata <= '0;
      for (int i = 0; i < 8; i++) r_regs[i] <= '0;
    end else begin
      r_pc <= w_pc_next;
      if (w_cir_load) r_cir <= instr_t'(instr);
      if (w_wr_en && !(R0_ZERO && (w_wr_idx == 3'd0))) r_regs[w_wr_idx] <= w_wr_data;
      if (w_set_illegal) r_illegal <= 1'b1;
      if (w_mem_start) begin
        r_mem_req   <= 1'b1;
        r_mem_we    <= (r_cir.op == OP_SW);
        r_mem_addr  <= ADDR_W'(w_ea);
        r_mem_wdata <= w_rt_val;
      end else if (r_mem_req && mem_ack) begin
        r_mem_req <= 1'b0;
      end
    end
  end

  assign pc        = r_pc;
  assign mem_req   = r_mem_req;
  assign mem_we    = r_mem_we;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign dbg_data  = r_regs[dbg_sel];
  assign halted    = (r_state == HALT);
  assign illegal   = r_illegal;

endmodule
`default_nettype wire
